// File: rtl/axi_xbar_pkg.sv
// Shared AXI crossbar types: log table geometry and the {valid, id, len} slot view.
// Used by the W-channel router and its output register slice.
package axi_xbar_pkg;

    localparam int WID_W     = 6;
    localparam int LEN_W     = 8;
    localparam int LOG_DEPTH = 3;

    typedef struct packed {
        logic             valid;
        logic [WID_W-1:0] id;
        logic [LEN_W-1:0] len;
    } log_slot_t;

    typedef logic [1:0] slot_idx_t;

    // Next slot index in round-robin order, wrapping after the last slot.
    function automatic slot_idx_t slot_inc(input slot_idx_t s);
        return (s == slot_idx_t'(LOG_DEPTH - 1)) ? '0 : s + slot_idx_t'(1);
    endfunction

endpackage

// File: rtl/w_out_reg.sv
// Single-entry valid/ready register slice with 1-cycle latency.
// Also reused for the B/R response paths, so the payload width is generic.
module w_out_reg #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [PAYLOAD_W-1:0] payload_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic [PAYLOAD_W-1:0] payload_o,
    output logic                 can_load_o
);

    logic                 valid_q, valid_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;

    // The caller may only assert load_i when can_load_o is high, so the
    // payload never changes while valid_o is high and ready_i is low.
    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        if (load_i) begin
            valid_d   = 1'b1;
            payload_d = payload_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

    assign valid_o    = valid_q;
    assign payload_o  = payload_q;
    assign can_load_o = !valid_q || ready_i;

endmodule

// File: rtl/write_data_router.sv
// Routes W beats from two masters to one slave using the write-address log table.
// Optional WLAST consistency check: define WRITE_DATA_WLAST_CHECK_EN.
module write_data_router
    import axi_xbar_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int INTERLEAVE_MODE = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              s_valid,
    input  logic [WID_W-1:0]        s_validid0,
    input  logic [WID_W-1:0]        s_validid1,
    input  logic [WID_W-1:0]        s_validid2,
    input  logic [LEN_W-1:0]        s_wlen0,
    input  logic [LEN_W-1:0]        s_wlen1,
    input  logic [LEN_W-1:0]        s_wlen2,
    input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
    input  logic [WID_W-1:0]        s0_axi_wid,
    input  logic                    s0_axi_wlast,
    input  logic                    s0_axi_wvalid,
    output logic                    s0_axi_wready,
    input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
    input  logic [WID_W-1:0]        s1_axi_wid,
    input  logic                    s1_axi_wlast,
    input  logic                    s1_axi_wvalid,
    output logic                    s1_axi_wready,
    output logic [DATA_WIDTH-1:0]   m_axi_w_data,
    output logic [DATA_WIDTH/8-1:0] m_axi_w_strb,
    output logic [WID_W-1:0]        m_axi_w_wid,
    output logic                    m_axi_w_wlast,
    output logic                    m_axi_w_valid,
    input  logic                    m_axi_w_ready,
    output logic                    log_wlast_fire,
    output logic [WID_W-1:0]        log_wid,
    output logic                    wlast_err
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int PAY_W  = WID_W + 1 + STRB_W + DATA_WIDTH;

    localparam logic [0:0] ST_OPEN   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

    log_slot_t            slot [LOG_DEPTH];
    logic [LOG_DEPTH-1:0] hit0, hit1, shadow, elig, src;

    logic [LEN_W-1:0]     cnt_q [LOG_DEPTH];
    logic [LEN_W-1:0]     cnt_d [LOG_DEPTH];
    slot_idx_t            ptr_q, ptr_d;
    logic [0:0]           lock_st_q, lock_st_d;
    slot_idx_t            lock_idx_q, lock_idx_d;

    slot_idx_t            grant_idx, cand;
    logic                 grant_vld;
    logic [LEN_W-1:0]     sel_len, sel_cnt;
    logic                 sel_src;
    logic                 gen_last;
    logic                 accept;
    logic                 out_can_load;

    logic [DATA_WIDTH-1:0] mst_data;
    logic [STRB_W-1:0]     mst_strb;
    logic [WID_W-1:0]      mst_wid;
    logic [PAY_W-1:0]      load_payload, out_payload;

    assign slot[0] = {s_valid[0], s_validid0, s_wlen0};
    assign slot[1] = {s_valid[1], s_validid1, s_wlen1};
    assign slot[2] = {s_valid[2], s_validid2, s_wlen2};

    for (genvar k = 0; k < LOG_DEPTH; k++) begin : g_slot
        assign hit0[k] = s0_axi_wvalid && (s0_axi_wid == slot[k].id);
        assign hit1[k] = s1_axi_wvalid && (s1_axi_wid == slot[k].id);
        // Master 0 wins when both masters present this slot's ID.
        assign src[k]  = !hit0[k];
        assign elig[k] = slot[k].valid && (hit0[k] || hit1[k]) && !shadow[k];
    end

    // A slot is hidden when a lower-indexed valid slot carries the same ID.
    always_comb begin
        shadow = '0;
        for (int k = 1; k < LOG_DEPTH; k++) begin
            for (int j = 0; j < k; j++) begin
                if (slot[j].valid && (slot[j].id == slot[k].id)) begin
                    shadow[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = ptr_q;
        cand      = ptr_q;
        if (lock_st_q == ST_LOCKED) begin
            grant_vld = elig[lock_idx_q];
            grant_idx = lock_idx_q;
        end else begin
            for (int n = 0; n < LOG_DEPTH; n++) begin
                if (!grant_vld && elig[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
                cand = slot_inc(cand);
            end
        end
    end

    always_comb begin
        sel_len = slot[0].len;
        sel_cnt = cnt_q[0];
        sel_src = src[0];
        case (grant_idx)
            2'd1: begin
                sel_len = slot[1].len;
                sel_cnt = cnt_q[1];
                sel_src = src[1];
            end
            2'd2: begin
                sel_len = slot[2].len;
                sel_cnt = cnt_q[2];
                sel_src = src[2];
            end
            default: ;
        endcase
    end

    // Handshake: a beat moves from a master into the output register when the
    // register is free or draining this cycle and some slot is granted; the
    // slave side completes a beat on m_axi_w_valid && m_axi_w_ready.
    assign gen_last      = (sel_cnt == sel_len);
    assign accept        = out_can_load && grant_vld;
    assign s0_axi_wready = accept && !sel_src;
    assign s1_axi_wready = accept && sel_src;

    assign mst_data     = sel_src ? s1_axi_wdata : s0_axi_wdata;
    assign mst_strb     = sel_src ? s1_axi_wstrb : s0_axi_wstrb;
    assign mst_wid      = sel_src ? s1_axi_wid   : s0_axi_wid;
    assign load_payload = {mst_wid, gen_last, mst_strb, mst_data};

    always_comb begin
        for (int k = 0; k < LOG_DEPTH; k++) begin
            cnt_d[k] = cnt_q[k];
            if (!slot[k].valid) begin
                cnt_d[k] = '0;
            end else if (accept && (grant_idx == slot_idx_t'(k))) begin
                cnt_d[k] = gen_last ? '0 : cnt_q[k] + CNT_ONE;
            end
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        lock_st_d  = lock_st_q;
        lock_idx_d = lock_idx_q;
        if (accept && ((INTERLEAVE_MODE != 0) || gen_last)) begin
            ptr_d = slot_inc(grant_idx);
        end
        if (INTERLEAVE_MODE == 0) begin
            if (accept) begin
                lock_st_d  = gen_last ? ST_OPEN : ST_LOCKED;
                lock_idx_d = grant_idx;
            end else if ((lock_st_q == ST_LOCKED) && !s_valid[lock_idx_q]) begin
                // Entry vanished under the lock; release rather than stall forever.
                lock_st_d = ST_OPEN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LOG_DEPTH; k++) begin
                cnt_q[k] <= '0;
            end
            ptr_q      <= '0;
            lock_st_q  <= ST_OPEN;
            lock_idx_q <= '0;
        end else begin
            for (int k = 0; k < LOG_DEPTH; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            ptr_q      <= ptr_d;
            lock_st_q  <= lock_st_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    w_out_reg #(
        .PAYLOAD_W (PAY_W)
    ) u_out_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .payload_i  (load_payload),
        .ready_i    (m_axi_w_ready),
        .valid_o    (m_axi_w_valid),
        .payload_o  (out_payload),
        .can_load_o (out_can_load)
    );

    assign {m_axi_w_wid, m_axi_w_wlast, m_axi_w_strb, m_axi_w_data} = out_payload;

    assign log_wlast_fire = m_axi_w_valid && m_axi_w_ready && m_axi_w_wlast;
    assign log_wid        = m_axi_w_wid;

`ifdef WRITE_DATA_WLAST_CHECK_EN
    logic mst_wlast;
    logic err_q, err_d;

    assign mst_wlast = sel_src ? s1_axi_wlast : s0_axi_wlast;

    always_comb begin
        err_d = err_q;
        if (accept && (mst_wlast != gen_last)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign wlast_err = err_q;
`else
    logic unused_wlast;
    assign unused_wlast = s0_axi_wlast ^ s1_axi_wlast;
    assign wlast_err    = 1'b0;
`endif

endmodule

// File: tb/tb_write_data_router.sv
// Directed bench for write_data_router: interleaved and burst-locked instances
// share stimulus; sel picks which instance's outputs are scored.
module tb_write_data_router;

    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int BW = 6 + 1 + SW + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cycle = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    // ---------------- DUT signals ----------------
    logic [2:0]    s_valid = '0;
    logic [5:0]    s_validid0 = '0, s_validid1 = '0, s_validid2 = '0;
    logic [7:0]    s_wlen0 = '0, s_wlen1 = '0, s_wlen2 = '0;
    logic [DW-1:0] s0_wdata, s1_wdata;
    logic [SW-1:0] s0_wstrb, s1_wstrb;
    logic [5:0]    s0_wid, s1_wid;
    logic          s0_wlast, s1_wlast;
    logic          s0_wvalid = 1'b0, s1_wvalid = 1'b0;
    logic          m_ready = 1'b1;
    logic          sel = 1'b0;

    logic          a_w0_rdy, a_w1_rdy, a_valid, a_wlast, a_fire, a_err;
    logic [DW-1:0] a_data;
    logic [SW-1:0] a_strb;
    logic [5:0]    a_wid, a_log_wid;
    logic          b_w0_rdy, b_w1_rdy, b_valid, b_wlast, b_fire, b_err;
    logic [DW-1:0] b_data;
    logic [SW-1:0] b_strb;
    logic [5:0]    b_wid, b_log_wid;

    logic          w0_rdy, w1_rdy, m_valid, m_wlast, log_fire, wlast_err;
    logic [DW-1:0] m_data;
    logic [SW-1:0] m_strb;
    logic [5:0]    m_wid, log_wid;

    write_data_router #(.DATA_WIDTH(DW), .INTERLEAVE_MODE(1)) u_dut_il (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid),
        .s_validid0(s_validid0), .s_validid1(s_validid1), .s_validid2(s_validid2),
        .s_wlen0(s_wlen0), .s_wlen1(s_wlen1), .s_wlen2(s_wlen2),
        .s0_axi_wdata(s0_wdata), .s0_axi_wstrb(s0_wstrb), .s0_axi_wid(s0_wid),
        .s0_axi_wlast(s0_wlast), .s0_axi_wvalid(s0_wvalid), .s0_axi_wready(a_w0_rdy),
        .s1_axi_wdata(s1_wdata), .s1_axi_wstrb(s1_wstrb), .s1_axi_wid(s1_wid),
        .s1_axi_wlast(s1_wlast), .s1_axi_wvalid(s1_wvalid), .s1_axi_wready(a_w1_rdy),
        .m_axi_w_data(a_data), .m_axi_w_strb(a_strb), .m_axi_w_wid(a_wid),
        .m_axi_w_wlast(a_wlast), .m_axi_w_valid(a_valid), .m_axi_w_ready(m_ready),
        .log_wlast_fire(a_fire), .log_wid(a_log_wid), .wlast_err(a_err)
    );

    write_data_router #(.DATA_WIDTH(DW), .INTERLEAVE_MODE(0)) u_dut_bl (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid),
        .s_validid0(s_validid0), .s_validid1(s_validid1), .s_validid2(s_validid2),
        .s_wlen0(s_wlen0), .s_wlen1(s_wlen1), .s_wlen2(s_wlen2),
        .s0_axi_wdata(s0_wdata), .s0_axi_wstrb(s0_wstrb), .s0_axi_wid(s0_wid),
        .s0_axi_wlast(s0_wlast), .s0_axi_wvalid(s0_wvalid), .s0_axi_wready(b_w0_rdy),
        .s1_axi_wdata(s1_wdata), .s1_axi_wstrb(s1_wstrb), .s1_axi_wid(s1_wid),
        .s1_axi_wlast(s1_wlast), .s1_axi_wvalid(s1_wvalid), .s1_axi_wready(b_w1_rdy),
        .m_axi_w_data(b_data), .m_axi_w_strb(b_strb), .m_axi_w_wid(b_wid),
        .m_axi_w_wlast(b_wlast), .m_axi_w_valid(b_valid), .m_axi_w_ready(m_ready),
        .log_wlast_fire(b_fire), .log_wid(b_log_wid), .wlast_err(b_err)
    );

    always_comb begin
        if (sel) begin
            {w0_rdy, w1_rdy, m_valid, m_wlast, log_fire, wlast_err} =
                {b_w0_rdy, b_w1_rdy, b_valid, b_wlast, b_fire, b_err};
            {m_data, m_strb, m_wid, log_wid} = {b_data, b_strb, b_wid, b_log_wid};
        end else begin
            {w0_rdy, w1_rdy, m_valid, m_wlast, log_fire, wlast_err} =
                {a_w0_rdy, a_w1_rdy, a_valid, a_wlast, a_fire, a_err};
            {m_data, m_strb, m_wid, log_wid} = {a_data, a_strb, a_wid, a_log_wid};
        end
    end

    // ---------------- scoreboard state ----------------
    logic [BW-1:0] q0[$], q1[$];
    logic [BW-1:0] exp_q[$];
    logic [5:0]    log_q[$];
    int            beat_cyc[$];
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] beat(input logic [5:0] wid, input logic last,
                                           input logic [DW-1:0] data);
        return {wid, last, data[SW-1:0], data};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic present_heads();
        if (q0.size() > 0) begin
            {s0_wid, s0_wlast, s0_wstrb, s0_wdata} = q0[0];
            s0_wvalid = 1'b1;
        end else begin
            {s0_wid, s0_wlast, s0_wstrb, s0_wdata} = '0;
            s0_wvalid = 1'b0;
        end
        if (q1.size() > 0) begin
            {s1_wid, s1_wlast, s1_wstrb, s1_wdata} = q1[0];
            s1_wvalid = 1'b1;
        end else begin
            {s1_wid, s1_wlast, s1_wstrb, s1_wdata} = '0;
            s1_wvalid = 1'b0;
        end
    endtask

    task automatic at_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        at_edge();
        rst_n   = 1'b0;
        s_valid = '0;
        m_ready = 1'b1;
        q0.delete();
        q1.delete();
        exp_q.delete();
        log_q.delete();
        beat_cyc.delete();
        present_heads();
        @(negedge clk);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_w0_ready", 64'(w0_rdy), 64'd0);
        check("rst_log_fire", 64'(log_fire), 64'd0);
        check("rst_wlast_err", 64'(wlast_err), 64'd0);
        at_edge();
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_log(input string tag, input int n, input logic [5:0] w0,
                             input logic [5:0] w1);
        check(tag, 64'(log_q.size()), 64'(n));
        if (log_q.size() > 0) check(tag, 64'(log_q[0]), 64'(w0));
        if (n > 1 && log_q.size() > 1) check(tag, 64'(log_q[1]), 64'(w1));
    endtask

    // Master model: a beat leaves its queue after the edge that accepted it.
    initial begin
        logic f0, f1;
        forever begin
            @(negedge clk);
            f0 = s0_wvalid && w0_rdy;
            f1 = s1_wvalid && w1_rdy;
            @(posedge clk);
            #1;
            if (f0 && q0.size() > 0) void'(q0.pop_front());
            if (f1 && q1.size() > 0) void'(q1.pop_front());
            present_heads();
        end
    end

    // Slave-side monitor and scoreboard.
    initial begin
        logic [BW-1:0] obs;
        forever begin
            @(negedge clk);
            if (rst_n && m_valid && m_ready) begin
                obs = {m_wid, m_wlast, m_strb, m_data};
                beat_cyc.push_back(cycle);
                if (exp_q.size() == 0) check("extra_beat", 64'(exp_q.size()), 64'd1);
                else check("beat", 64'(obs), 64'(exp_q.pop_front()));
            end
            if (rst_n && log_fire) log_q.push_back(log_wid);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        logic exp_err;
        present_heads();

        // Single 4-beat burst, streaming.
        sel = 1'b0;
        do_reset();
        s_validid0 = 6'd5;
        s_wlen0    = 8'd3;
        for (int i = 0; i < 4; i++) begin
            q0.push_back(beat(6'd5, i == 3, 32'(32'hA0 + i)));
            exp_q.push_back(beat(6'd5, i == 3, 32'(32'hA0 + i)));
        end
        present_heads();
        s_valid = 3'b001;
        wait_drain(40);
        check("t1_nbeats", 64'(beat_cyc.size()), 64'd4);
        if (beat_cyc.size() == 4) check("t1_span", 64'(beat_cyc[3] - beat_cyc[0]), 64'd3);
        check_log("t1_log", 1, 6'd5, 6'd0);

        // Two masters, interleaved then burst-locked.
        for (int m = 0; m < 2; m++) begin
            sel = (m == 1);
            do_reset();
            s_validid0 = 6'd2; s_wlen0 = 8'd1;
            s_validid1 = 6'd9; s_wlen1 = 8'd1;
            q0.push_back(beat(6'd2, 1'b0, 32'h20));
            q0.push_back(beat(6'd2, 1'b1, 32'h21));
            q1.push_back(beat(6'd9, 1'b0, 32'h90));
            q1.push_back(beat(6'd9, 1'b1, 32'h91));
            if (m == 0) begin
                exp_q.push_back(beat(6'd2, 1'b0, 32'h20));
                exp_q.push_back(beat(6'd9, 1'b0, 32'h90));
                exp_q.push_back(beat(6'd2, 1'b1, 32'h21));
                exp_q.push_back(beat(6'd9, 1'b1, 32'h91));
            end else begin
                exp_q.push_back(beat(6'd2, 1'b0, 32'h20));
                exp_q.push_back(beat(6'd2, 1'b1, 32'h21));
                exp_q.push_back(beat(6'd9, 1'b0, 32'h90));
                exp_q.push_back(beat(6'd9, 1'b1, 32'h91));
            end
            present_heads();
            s_valid = 3'b011;
            wait_drain(40);
            check_log("t2_log", 2, 6'd2, 6'd9);
        end

        // Slave stall with a beat held in the output register.
        sel = 1'b0;
        do_reset();
        m_ready    = 1'b0;
        s_validid0 = 6'd3;
        s_wlen0    = 8'd3;
        for (int i = 0; i < 4; i++) begin
            q0.push_back(beat(6'd3, i == 3, 32'(32'h30 + i)));
            exp_q.push_back(beat(6'd3, i == 3, 32'(32'h30 + i)));
        end
        present_heads();
        s_valid = 3'b001;
        at_edge();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_hold_valid", 64'(m_valid), 64'd1);
            check("t4_hold_data", 64'(m_data), 64'h30);
            check("t4_w0_ready", 64'(w0_rdy), 64'd0);
            check("t4_w1_ready", 64'(w1_rdy), 64'd0);
        end
        at_edge();
        m_ready = 1'b1;
        wait_drain(40);
        check("t4_nbeats", 64'(beat_cyc.size()), 64'd4);
        check_log("t4_log", 1, 6'd3, 6'd0);

        // ID not in the table, then the table learns it.
        do_reset();
        s_validid0 = 6'd4; s_wlen0 = 8'd0;
        q0.push_back(beat(6'd7, 1'b1, 32'h70));
        exp_q.push_back(beat(6'd7, 1'b1, 32'h70));
        present_heads();
        s_valid = 3'b001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_no_ready", 64'(w0_rdy), 64'd0);
            check("t5_idle", 64'(m_valid), 64'd0);
        end
        at_edge();
        s_validid1 = 6'd7; s_wlen1 = 8'd0;
        s_valid    = 3'b011;
        @(negedge clk);
        check("t5_ready", 64'(w0_rdy), 64'd1);
        wait_drain(40);
        check_log("t5_log", 1, 6'd7, 6'd0);

        // Master WLAST on the wrong beat.
        do_reset();
        s_validid0 = 6'd1; s_wlen0 = 8'd1;
        q0.push_back(beat(6'd1, 1'b1, 32'h10));
        q0.push_back(beat(6'd1, 1'b0, 32'h11));
        exp_q.push_back(beat(6'd1, 1'b0, 32'h10));
        exp_q.push_back(beat(6'd1, 1'b1, 32'h11));
        present_heads();
        s_valid = 3'b001;
        wait_drain(40);
`ifdef WRITE_DATA_WLAST_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        check("t6_err", 64'(wlast_err), 64'(exp_err));
        at_edge();
        s_valid = 3'b000;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t6_err_sticky", 64'(wlast_err), 64'(exp_err));

        // Duplicate ID: lower slot (len 0) must win over slot 2 (len 1).
        do_reset();
        s_validid1 = 6'd6; s_wlen1 = 8'd0;
        s_validid2 = 6'd6; s_wlen2 = 8'd1;
        q0.push_back(beat(6'd6, 1'b1, 32'h60));
        exp_q.push_back(beat(6'd6, 1'b1, 32'h60));
        present_heads();
        s_valid = 3'b110;
        wait_drain(40);
        check_log("t7_log", 1, 6'd6, 6'd0);

        // Longest burst on the last slot, burst-locked instance.
        sel = 1'b1;
        do_reset();
        s_validid2 = 6'h3F; s_wlen2 = 8'hFF;
        for (int i = 0; i < 256; i++) begin
            q1.push_back(beat(6'h3F, i == 255, 32'(32'h1000 + i)));
            exp_q.push_back(beat(6'h3F, i == 255, 32'(32'h1000 + i)));
        end
        present_heads();
        s_valid = 3'b100;
        wait_drain(300);
        check("t8_nbeats", 64'(beat_cyc.size()), 64'd256);
        check_log("t8_log", 1, 6'h3F, 6'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
